// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the streaming memory loader.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        WORD,
        WRITE,
        CSUM,
        DONE,
        ERR
    } mem_loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    function automatic logic accepts_bytes(input mem_loader_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == WORD) || (s == CSUM);
    endfunction

endpackage

// File: rtl/mem_loader_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first and flags the
// byte that completes a word so the caller can capture word in the same cycle.
module byte_word_assembler
    import mem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              data,
    input  logic                    take,
    output logic [WORD_BYTES*8-1:0] word,
    output logic                    word_valid
);

    localparam int CNT_W = $clog2(WORD_BYTES);
    localparam int SH_W  = (WORD_BYTES - 1) * 8;

    logic [CNT_W-1:0] count;
    logic [SH_W-1:0]  shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            shift <= '0;
        end else if (take) begin
            count <= count + CNT_W'(1);
            shift <= {shift[SH_W-9:0], data};
        end
    end

    // The completing byte is appended combinationally so no extra cycle is spent.
    assign word       = {shift, data};
    assign word_valid = take && (count == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/mem_loader.sv
// Streaming program/data loader: length header, big-endian words, one write per
// word, core held until the image is complete. Optional MEM_LOADER_CHECKSUM_EN.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned ADDR_INCR = 4,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        core_hold,
    output logic        done,
    output logic        error
);

    localparam int LEN_W = HDR_BYTES * 8;
    localparam logic [LEN_W:0] ONE = 1;
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam mem_loader_state_t AFTER_IMAGE = CSUM;
`else
    localparam mem_loader_state_t AFTER_IMAGE = DONE;
`endif

    mem_loader_state_t state, state_n;
    logic              accept;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  len, len_rx, idx;
    logic [LEN_W:0]    idx_inc;
    logic [31:0]       word, word_addr;
    logic              word_valid;
    logic              in_ready_n, mem_write_n, core_hold_n, done_n, error_n;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum, csum_n;
    assign csum_n = csum + in_data;
`endif

    assign accept    = in_valid & in_ready;
    assign len_rx    = {len_hi, in_data};
    assign idx_inc   = {1'b0, idx} + ONE;
    assign word_addr = BASE_ADDR + 32'(idx) * ADDR_INCR;

    byte_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .data       (in_data),
        .take       (accept && (state == WORD)),
        .word       (word),
        .word_valid (word_valid)
    );

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_write <= 1'b0;
            core_hold <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= in_ready_n;
            mem_write <= mem_write_n;
            core_hold <= core_hold_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   state_n = LEN_HI;
            LEN_HI: if (accept) state_n = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (32'(len_rx) > MAX_WORDS) state_n = ERR;
                    else if (len_rx == '0)       state_n = AFTER_IMAGE;
                    else                         state_n = WORD;
                end
            end
            WORD:   if (word_valid) state_n = WRITE;
            WRITE:  state_n = (idx_inc < {1'b0, len}) ? WORD : AFTER_IMAGE;
`ifdef MEM_LOADER_CHECKSUM_EN
            CSUM:   if (accept) state_n = (csum_n == 8'h00) ? DONE : ERR;
`endif
            DONE:   state_n = DONE;
            ERR:    state_n = ERR;
            default: state_n = state;
        endcase
    end

    always_comb begin
        in_ready_n  = accepts_bytes(state_n);
        mem_write_n = (state_n == WRITE);
        core_hold_n = (state_n != DONE);
        done_n      = (state_n == DONE);
        error_n     = (state_n == ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi         <= '0;
            len            <= '0;
            idx            <= '0;
            mem_address    <= BASE_ADDR;
            mem_write_data <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            if (accept && (state == LEN_HI)) len_hi <= in_data;
            if (accept && (state == LEN_LO)) len    <= len_rx;
            if (word_valid) begin
                mem_address    <= word_addr;
                mem_write_data <= word;
            end
            if (state == WRITE) idx <= idx + LEN_W'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
            if (accept) csum <= csum_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: two instances (default and BASE 0x100 / INCR 1 / MAX 4).
module tb_mem_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data [2];
    logic [1:0]  in_valid;
    wire  [1:0]  in_ready, mem_write, core_hold, done, error;
    wire  [31:0] mem_address [2];
    wire  [31:0] mem_write_data [2];

    wr_t         exp_q0[$];
    wr_t         exp_q1[$];
    wr_t         e0, e1;
    logic [7:0]  stream_q[$];
    logic [31:0] img [4];
    int          checks = 0;
    int          failures = 0;
    int          wr_cnt0 = 0;
    int          wr_cnt1 = 0;
    int          wr_before;

    always #5 clk = ~clk;

    mem_loader u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .mem_address(mem_address[0]),
        .mem_write_data(mem_write_data[0]), .mem_write(mem_write[0]),
        .core_hold(core_hold[0]), .done(done[0]), .error(error[0])
    );

    mem_loader #(.BASE_ADDR(32'h100), .ADDR_INCR(1), .MAX_WORDS(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .mem_address(mem_address[1]),
        .mem_write_data(mem_write_data[1]), .mem_write(mem_write[1]),
        .core_hold(core_hold[1]), .done(done[1]), .error(error[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write[0] === 1'b1) begin
            wr_cnt0++;
            if (exp_q0.size() == 0) check("wr0_unexpected", 32'(exp_q0.size()), 32'd1);
            else begin
                e0 = exp_q0.pop_front();
                check("wr0_addr", mem_address[0], e0.addr);
                check("wr0_data", mem_write_data[0], e0.data);
            end
        end
    end

    always @(negedge clk) begin
        if (mem_write[1] === 1'b1) begin
            wr_cnt1++;
            if (exp_q1.size() == 0) check("wr1_unexpected", 32'(exp_q1.size()), 32'd1);
            else begin
                e1 = exp_q1.pop_front();
                check("wr1_addr", mem_address[1], e1.addr);
                check("wr1_data", mem_write_data[1], e1.data);
            end
        end
    end

    task automatic make_stream(input logic [15:0] n, input int nw);
        logic [7:0]  s;
        logic [31:0] w;
        stream_q.delete();
        stream_q.push_back(n[15:8]);
        stream_q.push_back(n[7:0]);
        for (int k = 0; k < nw; k++) begin
            w = img[k];
            stream_q.push_back(w[31:24]);
            stream_q.push_back(w[23:16]);
            stream_q.push_back(w[15:8]);
            stream_q.push_back(w[7:0]);
        end
        if (CSUM_ON) begin
            s = 8'h00;
            foreach (stream_q[i]) s = s + stream_q[i];
            stream_q.push_back(8'h00 - s);
        end
    endtask

    task automatic push_expected(input int u, input int nw);
        wr_t e;
        for (int k = 0; k < nw; k++) begin
            e.data = img[k];
            if (u == 0) begin
                e.addr = 32'(k) * 32'd4;
                exp_q0.push_back(e);
            end else begin
                e.addr = 32'h100 + 32'(k);
                exp_q1.push_back(e);
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send_byte(input int u, input logic [7:0] b);
        int n = 0;
        in_data[u]  = b;
        in_valid[u] = 1'b1;
        while (in_ready[u] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        in_valid[u] = 1'b0;
    endtask

    task automatic send_stream(input int u, input bit gaps);
        foreach (stream_q[i]) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(u, stream_q[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_done(input int u, input bit pending_write);
        if (pending_write && !CSUM_ON) begin
            check("done_before_last_wr", 32'(done[u]), 32'd0);
            check("last_wr_strobe", 32'(mem_write[u]), 32'd1);
            @(negedge clk);
        end
        check("done", 32'(done[u]), 32'd1);
        check("core_hold_low", 32'(core_hold[u]), 32'd0);
        check("no_error", 32'(error[u]), 32'd0);
        check("ready_after_image", 32'(in_ready[u]), 32'd0);
        check("queue_drained", 32'(u == 0 ? exp_q0.size() : exp_q1.size()), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 2'b00;
        in_data[0]  = 8'h00;
        in_data[1]  = 8'h00;
        img[0] = 32'h20080005;
        img[1] = 32'hAC080008;
        img[2] = 32'h12345678;
        img[3] = 32'hDEADBEEF;
        repeat (2) @(negedge clk);

        for (int u = 0; u < 2; u++) begin
            check("rst_in_ready", 32'(in_ready[u]), 32'd0);
            check("rst_mem_write", 32'(mem_write[u]), 32'd0);
            check("rst_mem_address", mem_address[u], (u == 0) ? 32'h0 : 32'h100);
            check("rst_mem_write_data", mem_write_data[u], 32'h0);
            check("rst_core_hold", 32'(core_hold[u]), 32'd1);
            check("rst_done", 32'(done[u]), 32'd0);
            check("rst_error", 32'(error[u]), 32'd0);
        end

        rst = 1'b0;
        check("ready_at_release", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        check("ready_after_1st_edge", 32'(in_ready[0]), 32'd1);

        // two-word load
        make_stream(16'd2, 2);
        push_expected(0, 2);
        send_stream(0, 1'b0);
        expect_done(0, 1'b1);
        in_data[0]  = 8'h55;
        in_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("trailing_byte_refused", 32'(in_ready[0]), 32'd0);
        end
        in_valid[0] = 1'b0;

        // same image with random valid gaps
        do_reset();
        make_stream(16'd2, 2);
        push_expected(0, 2);
        send_stream(0, 1'b1);
        expect_done(0, 1'b1);

        // asynchronous reset in the middle of a word, then a full restream
        do_reset();
        make_stream(16'd2, 2);
        for (int i = 0; i < 5; i++) send_byte(0, stream_q[i]);
        check("mid_ready_before_rst", 32'(in_ready[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ready", 32'(in_ready[0]), 32'd0);
        check("async_rst_hold", 32'(core_hold[0]), 32'd1);
        check("async_rst_write", 32'(mem_write[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_expected(0, 2);
        send_stream(0, 1'b0);
        expect_done(0, 1'b1);

        if (CSUM_ON) begin
            do_reset();
            make_stream(16'd2, 2);
            stream_q[stream_q.size() - 1] = stream_q[stream_q.size() - 1] + 8'h01;
            push_expected(0, 2);
            send_stream(0, 1'b0);
            check("bad_csum_error", 32'(error[0]), 32'd1);
            check("bad_csum_done", 32'(done[0]), 32'd0);
            check("bad_csum_hold", 32'(core_hold[0]), 32'd1);
            check("bad_csum_ready", 32'(in_ready[0]), 32'd0);
        end

        // zero-length image
        do_reset();
        wr_before = wr_cnt0;
        make_stream(16'd0, 0);
        send_stream(0, 1'b0);
        expect_done(0, 1'b0);
        check("zero_len_no_write", 32'(wr_cnt0 - wr_before), 32'd0);

        // length overflow on the MAX_WORDS=4 instance
        do_reset();
        make_stream(16'd5, 0);
        send_byte(1, stream_q[0]);
        send_byte(1, stream_q[1]);
        check("ovf_error", 32'(error[1]), 32'd1);
        check("ovf_done", 32'(done[1]), 32'd0);
        check("ovf_hold", 32'(core_hold[1]), 32'd1);
        in_data[1]  = 8'hA5;
        in_valid[1] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("ovf_ready_low", 32'(in_ready[1]), 32'd0);
        end
        in_valid[1] = 1'b0;
        check("ovf_no_write", 32'(wr_cnt1), 32'd0);

        // base/increment parameters, three words with gaps
        do_reset();
        make_stream(16'd3, 3);
        push_expected(1, 3);
        send_stream(1, 1'b1);
        expect_done(1, 1'b1);

        // exactly MAX_WORDS words is accepted
        do_reset();
        make_stream(16'd4, 4);
        push_expected(1, 4);
        send_stream(1, 1'b0);
        expect_done(1, 1'b1);
        check("max_words_write_count", 32'(wr_cnt1), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
